// File: rtl/fo_arbiter_if.sv
// -----------------------------------------------------------------------------
// fo_arbiter_if
// Bundles the requester-side and core-side signals of fo_arbiter.
//   slave  : the arbiter's view (requests and core results in, grants,
//            core issue, responses and status out)
//   master : the environment's view (requesters plus FO core)
// Requester k occupies slice k of every packed per-requester bus:
//   req_plain_i [32k+31:32k], req_key_I_i [48k+47:48k], req_key_O_i [64k+63:64k]
// -----------------------------------------------------------------------------
interface fo_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // requester side
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*32-1:0] req_plain_i;
    logic [NREQ*48-1:0] req_key_I_i;
    logic [NREQ*64-1:0] req_key_O_i;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [31:0]        rsp_sypher_o;

    // FO core side
    logic               fo_valid_o;
    logic [31:0]        fo_plain_o;
    logic [47:0]        fo_key_I_o;
    logic [63:0]        fo_key_O_o;
    logic               fo_ready_i;
    logic               fo_valid_i;
    logic [31:0]        fo_sypher_i;

    // status
    logic [CW-1:0]      outstanding_o;
    logic               err_o;

    modport slave (
        input  req_valid_i, req_plain_i, req_key_I_i, req_key_O_i,
        input  fo_ready_i, fo_valid_i, fo_sypher_i,
        output req_ready_o, rsp_valid_o, rsp_sypher_o,
        output fo_valid_o, fo_plain_o, fo_key_I_o, fo_key_O_o,
        output outstanding_o, err_o
    );

    modport master (
        output req_valid_i, req_plain_i, req_key_I_i, req_key_O_i,
        output fo_ready_i, fo_valid_i, fo_sypher_i,
        input  req_ready_o, rsp_valid_o, rsp_sypher_o,
        input  fo_valid_o, fo_plain_o, fo_key_I_o, fo_key_O_o,
        input  outstanding_o, err_o
    );
endinterface

// File: rtl/fo_arbiter.sv
// -----------------------------------------------------------------------------
// fo_arbiter
// Round-robin arbiter sharing one FO datapath core between NREQ requesters.
// One request per cycle is forwarded combinationally to the core over its
// valid/ready handshake; the owner of every accepted request is queued in a
// tag FIFO, and each core result is routed back to that owner one registered
// cycle later. The block performs no computation on the data.
//
// Ports
//   clk      : clock, rising edge
//   aresetn  : asynchronous active-low reset
//   bus      : fo_arbiter_if.slave
//     req_valid_i/req_plain_i/req_key_I_i/req_key_O_i : requests in
//     req_ready_o   : one-hot accept to the granted requester
//     rsp_valid_o   : one-hot result strobe, rsp_sypher_o shared result word
//     fo_valid_o/fo_plain_o/fo_key_I_o/fo_key_O_o     : issue to core
//     fo_ready_i, fo_valid_i, fo_sypher_i             : core handshake/result
//     outstanding_o : operations in flight
//     err_o         : sticky, core result seen with no outstanding tag
// -----------------------------------------------------------------------------
module fo_arbiter #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic        clk,
    input  logic        aresetn,
    fo_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // (base + off) mod NREQ for base < NREQ and off < NREQ
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                 input int unsigned   off);
        int unsigned sum;
        sum = {{(32-IDW){1'b0}}, base} + off;
        if (sum >= unsigned'(NREQ)) begin
            sum = sum - unsigned'(NREQ);
        end
        return sum[IDW-1:0];
    endfunction

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic            any_vld;
    logic            full;
    logic            empty;
    logic            issue;
    logic            hs;
    logic            pop;
    logic            spurious;

    logic [IDW-1:0]  tag_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            err_q;

    logic [NREQ-1:0] req_ready;
    logic [31:0]     fo_plain;
    logic [47:0]     fo_key_I;
    logic [63:0]     fo_key_O;

    logic [NREQ-1:0] rsp_vld_p1;
    logic [31:0]     rsp_data_p1;

    // ---- stage p0: grant and combinational issue to the core ----

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        any_vld = 1'b0;
        gnt_id  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_vld && bus.req_valid_i[wrap_add(rr_ptr, unsigned'(i))]) begin
                any_vld = 1'b1;
                gnt_id  = wrap_add(rr_ptr, unsigned'(i));
            end
        end
    end

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    // Gating with aresetn keeps every combinational output at 0 during reset.
    // Full is judged on the registered count, so a pop in the same cycle
    // cannot open a slot until the next cycle.
    assign issue    = any_vld & ~full & aresetn;
    assign hs       = issue & bus.fo_ready_i;
    assign pop      = bus.fo_valid_i & ~empty;
    assign spurious = bus.fo_valid_i & empty;

    always_comb begin
        fo_plain  = '0;
        fo_key_I  = '0;
        fo_key_O  = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (issue && (IDW'(i) == gnt_id)) begin
                fo_plain = bus.req_plain_i[32*i +: 32];
                fo_key_I = bus.req_key_I_i[48*i +: 48];
                fo_key_O = bus.req_key_O_i[64*i +: 64];
                req_ready[i] = bus.fo_ready_i;
            end
        end
    end

    assign bus.fo_valid_o  = issue;
    assign bus.fo_plain_o  = fo_plain;
    assign bus.fo_key_I_o  = fo_key_I;
    assign bus.fo_key_O_o  = fo_key_O;
    assign bus.req_ready_o = req_ready;

    // Tag storage carries no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        if (hs) begin
            tag_mem[wr_ptr] <= gnt_id;
        end
    end

    // ---- stage p1: registered control, tag FIFO and response ----
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rr_ptr      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_q       <= 1'b0;
            rsp_vld_p1  <= '0;
            rsp_data_p1 <= '0;
        end else begin
            if (hs) begin
                rr_ptr <= wrap_add(gnt_id, 1);
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end

            unique case ({hs, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (spurious) begin
                err_q <= 1'b1;
            end

            // Single-cycle strobe to the owner; the result word holds
            // between responses.
            rsp_vld_p1 <= '0;
            if (pop) begin
                rsp_vld_p1[tag_mem[rd_ptr]] <= 1'b1;
                rsp_data_p1                 <= bus.fo_sypher_i;
            end
        end
    end

    assign bus.rsp_valid_o   = rsp_vld_p1;
    assign bus.rsp_sypher_o  = rsp_data_p1;
    assign bus.outstanding_o = count;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_fo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fo_arbiter
// Bench for fo_arbiter with NREQ=2, DEPTH=4 and a modelled FO core of
// DURATION 3. A vector table drives request/ready patterns with literal
// expected grants; hand-written sequences cover full FIFO, owner ordering,
// spurious results and mid-flight reset. Every accepted request pushes its
// expected owner and result into a scoreboard that is popped when the
// response is due.
// -----------------------------------------------------------------------------
module tb_fo_arbiter;
    localparam int NREQ  = 2;
    localparam int DEPTH = 4;
    localparam int DUR   = 3;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic aresetn;
    always #5 clk = ~clk;

    fo_arbiter_if #(.NREQ(NREQ), .DEPTH(DEPTH)) bus ();

    fo_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic [NREQ-1:0] vld;
        logic            rdy;
        logic [NREQ-1:0] exp_rdy;
        logic            exp_fv;
    } vec_t;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          issue;
    } sb_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } core_t;

    sb_t             sb[$];
    core_t           pend[$];
    logic [NREQ-1:0] rsp_log[$];

    int          cyc;
    int          n_chk;
    int          n_fail;
    int          m_cnt;
    int          m_rr;
    logic        m_err;
    logic [31:0] m_last;
    logic [31:0] plain [NREQ];
    bit          core_stall;
    bit          spur;
    bit          chk_lat;

    // FO core stand-in: any fixed, non-trivial mapping of the plaintext.
    function automatic logic [31:0] fcore(input logic [31:0] p);
        return (p * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [47:0] key_i_of(input logic [31:0] p);
        return {~p[15:0], p};
    endfunction

    function automatic logic [63:0] key_o_of(input logic [31:0] p);
        return {p, ~p};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_plain_i[32*k +: 32] = plain[k];
            bus.req_key_I_i[48*k +: 48] = key_i_of(plain[k]);
            bus.req_key_O_i[64*k +: 64] = key_o_of(plain[k]);
        end
    endtask

    // One clock cycle. Entered and left 1 time unit after a rising edge with
    // the requester inputs for this cycle already applied.
    task automatic tick(input bit has_exp, input logic [NREQ-1:0] x_rdy, input logic x_fv);
        bit              deliver;
        bit              any;
        bit              e_fv;
        bit              e_hs;
        bit              e_pop;
        int              g;
        logic [NREQ-1:0] e_rdy;
        sb_t             s;

        deliver = 1'b0;
        if (!core_stall && pend.size() > 0) begin
            if (pend[0].due <= cyc) deliver = 1'b1;
        end
        bus.fo_valid_i  = deliver | spur;
        bus.fo_sypher_i = 32'hDEAD_BEEF;
        if (deliver) bus.fo_sypher_i = pend[0].data;
        #1;

        any = 1'b0;
        g   = 0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_rr + i) % NREQ;
            if (!any && bus.req_valid_i[k]) begin
                any = 1'b1;
                g   = k;
            end
        end
        e_fv  = any && (m_cnt < DEPTH);
        e_hs  = e_fv && bus.fo_ready_i;
        e_rdy = '0;
        if (e_hs) e_rdy[g] = 1'b1;

        chk("fo_valid_o", 64'(bus.fo_valid_o), 64'(e_fv));
        chk("req_ready_o", 64'(bus.req_ready_o), 64'(e_rdy));
        chk("fo_plain_o", 64'(bus.fo_plain_o), e_fv ? 64'(plain[g]) : 64'd0);
        chk("fo_key_I_o", 64'(bus.fo_key_I_o), e_fv ? 64'(key_i_of(plain[g])) : 64'd0);
        chk("fo_key_O_o", bus.fo_key_O_o, e_fv ? key_o_of(plain[g]) : 64'd0);
        if (has_exp) begin
            chk("vec_req_ready", 64'(bus.req_ready_o), 64'(x_rdy));
            chk("vec_fo_valid", 64'(bus.fo_valid_o), 64'(x_fv));
        end

        e_pop = bus.fo_valid_i && (m_cnt > 0);
        if (bus.fo_valid_i && m_cnt == 0) m_err = 1'b1;
        if (e_hs) begin
            sb.push_back('{g, fcore(plain[g]), cyc});
            pend.push_back('{cyc + DUR, fcore(plain[g])});
            m_rr = (g + 1) % NREQ;
        end
        m_cnt = m_cnt + (e_hs ? 1 : 0) - (e_pop ? 1 : 0);
        if (deliver) void'(pend.pop_front());

        @(posedge clk);
        cyc++;
        #1;

        if (bus.rsp_valid_o != '0) rsp_log.push_back(bus.rsp_valid_o);
        if (e_pop) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                s = sb.pop_front();
                chk("rsp_valid_o", 64'(bus.rsp_valid_o), 64'(1 << s.owner));
                chk("rsp_sypher_o", 64'(bus.rsp_sypher_o), 64'(s.data));
                if (chk_lat) chk("rsp_latency", 64'(cyc - s.issue), 64'(DUR + 1));
                m_last = s.data;
            end
        end else begin
            chk("rsp_valid_idle", 64'(bus.rsp_valid_o), 64'd0);
            chk("rsp_sypher_hold", 64'(bus.rsp_sypher_o), 64'(m_last));
        end
        chk("outstanding_o", 64'(bus.outstanding_o), 64'(m_cnt));
        chk("err_o", 64'(bus.err_o), 64'(m_err));

        // a requester changes its payload only after being accepted
        if (e_hs) begin
            plain[g] = plain[g] + 32'h1000_0003;
            drive_data();
        end
    endtask

    task automatic do_reset();
        aresetn         = 1'b0;
        bus.req_valid_i = '1;
        bus.fo_ready_i  = 1'b1;
        bus.fo_valid_i  = 1'b0;
        bus.fo_sypher_i = '0;
        spur            = 1'b0;
        core_stall      = 1'b0;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("rst_rsp_sypher", 64'(bus.rsp_sypher_o), 64'd0);
        chk("rst_fo_valid", 64'(bus.fo_valid_o), 64'd0);
        chk("rst_fo_plain", 64'(bus.fo_plain_o), 64'd0);
        chk("rst_fo_key_I", 64'(bus.fo_key_I_o), 64'd0);
        chk("rst_fo_key_O", bus.fo_key_O_o, 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        pend.delete();
        sb.delete();
        m_cnt  = 0;
        m_rr   = 0;
        m_err  = 1'b0;
        m_last = '0;
        repeat (2) @(posedge clk);
        #1;
        aresetn         = 1'b1;
        bus.req_valid_i = '0;
    endtask

    task automatic drain();
        bus.req_valid_i = '0;
        for (int i = 0; i < 30 && sb.size() > 0; i++) begin
            tick(1'b0, '0, 1'b0);
        end
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl [16];

        // both valid: 0,1,0 alternate, leaving rr_ptr at 1
        tbl[0]  = '{2'b11, 1'b1, 2'b01, 1'b1};
        tbl[1]  = '{2'b11, 1'b1, 2'b10, 1'b1};
        tbl[2]  = '{2'b11, 1'b1, 2'b01, 1'b1};
        // core not ready for 5 cycles: nothing accepted, priority held
        tbl[3]  = '{2'b11, 1'b0, 2'b00, 1'b1};
        tbl[4]  = '{2'b11, 1'b0, 2'b00, 1'b1};
        tbl[5]  = '{2'b11, 1'b0, 2'b00, 1'b1};
        tbl[6]  = '{2'b11, 1'b0, 2'b00, 1'b1};
        tbl[7]  = '{2'b11, 1'b0, 2'b00, 1'b1};
        // ready returns: requester 1 goes first, then 0
        tbl[8]  = '{2'b11, 1'b1, 2'b10, 1'b1};
        tbl[9]  = '{2'b11, 1'b1, 2'b01, 1'b1};
        tbl[10] = '{2'b01, 1'b1, 2'b01, 1'b1};
        tbl[11] = '{2'b00, 1'b1, 2'b00, 1'b0};
        tbl[12] = '{2'b00, 1'b1, 2'b00, 1'b0};
        tbl[13] = '{2'b00, 1'b1, 2'b00, 1'b0};
        tbl[14] = '{2'b00, 1'b1, 2'b00, 1'b0};
        tbl[15] = '{2'b00, 1'b1, 2'b00, 1'b0};

        n_chk           = 0;
        n_fail          = 0;
        cyc             = 0;
        m_cnt           = 0;
        m_rr            = 0;
        m_err           = 1'b0;
        m_last          = '0;
        core_stall      = 1'b0;
        spur            = 1'b0;
        chk_lat         = 1'b1;
        aresetn         = 1'b1;
        bus.req_valid_i = '0;
        bus.fo_ready_i  = 1'b0;
        bus.fo_valid_i  = 1'b0;
        bus.fo_sypher_i = '0;
        plain[0]        = 32'h0000_0001;
        plain[1]        = 32'hA000_0000;
        drive_data();

        @(posedge clk);
        #1;
        do_reset();

        // reset release, fairness, backpressure
        for (int i = 0; i < 16; i++) begin
            bus.req_valid_i = tbl[i].vld;
            bus.fo_ready_i  = tbl[i].rdy;
            tick(1'b1, tbl[i].exp_rdy, tbl[i].exp_fv);
        end
        drain();

        // full FIFO with a stalled core; a same-cycle pop does not free an issue
        chk_lat         = 1'b0;
        core_stall      = 1'b1;
        bus.fo_ready_i  = 1'b1;
        bus.req_valid_i = 2'b11;
        repeat (4) tick(1'b0, '0, 1'b0);
        chk("full_outstanding", 64'(bus.outstanding_o), 64'd4);
        tick(1'b1, 2'b00, 1'b0);
        core_stall = 1'b0;
        tick(1'b1, 2'b00, 1'b0);
        chk("full_after_pop", 64'(bus.outstanding_o), 64'd3);
        tick(1'b1, 2'b10, 1'b1);
        drain();

        // owners 1,0,1 come back in the same order
        rsp_log.delete();
        bus.req_valid_i = 2'b10;
        tick(1'b1, 2'b10, 1'b1);
        bus.req_valid_i = 2'b01;
        tick(1'b1, 2'b01, 1'b1);
        bus.req_valid_i = 2'b10;
        tick(1'b1, 2'b10, 1'b1);
        drain();
        chk("ooo_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            chk("ooo_rsp0", 64'(rsp_log[0]), 64'b10);
            chk("ooo_rsp1", 64'(rsp_log[1]), 64'b01);
            chk("ooo_rsp2", 64'(rsp_log[2]), 64'b10);
        end

        // spurious core result with nothing outstanding
        spur = 1'b1;
        tick(1'b0, '0, 1'b0);
        spur = 1'b0;
        chk("spur_err", 64'(bus.err_o), 64'd1);
        chk("spur_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        chk("spur_outstanding", 64'(bus.outstanding_o), 64'd0);
        tick(1'b0, '0, 1'b0);
        chk("err_sticky", 64'(bus.err_o), 64'd1);

        // reset with two operations in flight
        core_stall      = 1'b1;
        bus.req_valid_i = 2'b01;
        tick(1'b1, 2'b01, 1'b1);
        bus.req_valid_i = 2'b10;
        tick(1'b1, 2'b10, 1'b1);
        bus.req_valid_i = 2'b00;
        chk("mid_outstanding", 64'(bus.outstanding_o), 64'd2);
        do_reset();
        tick(1'b0, '0, 1'b0);

        // clean operation after reset, grant restarts at requester 0
        bus.req_valid_i = 2'b11;
        tick(1'b1, 2'b01, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
